// File: rtl/regfile_pkg.sv
// Shared constants and the read-path bypass source selector for the register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned INIT_ZERO  = 0;
  localparam int unsigned INIT_INDEX = 1;

  typedef enum logic [1:0] {
    SelArray = 2'd0,
    SelWb0   = 2'd1,
    SelWb1   = 2'd2,
    SelZero  = 2'd3
  } bypass_sel_e;

  // Addresses are passed zero-extended so one function serves every AW.
  function automatic bypass_sel_e bypass_sel(input logic [31:0] raddr,
                                             input logic        we0,
                                             input logic [31:0] wa0,
                                             input logic        we1,
                                             input logic [31:0] wa1);
    if (raddr == 32'd0) begin
      return SelZero;
    end else if (we1 && (wa1 == raddr)) begin
      return SelWb1;
    end else if (we0 && (wa0 == raddr)) begin
      return SelWb0;
    end
    return SelArray;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-load scoreboard: one busy bit per register, set on load issue, cleared by WB1.
module regfile_sb import regfile_pkg::*; #(
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NUM_RD = 2,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_iss_valid,
  input  logic [AW-1:0]        i_iss_rd,
  input  logic                 i_we1,
  input  logic [AW-1:0]        i_waddr1,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]    o_rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Set is applied after clear so a re-issue on the same edge keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_we1) begin
      w_busy_nxt[i_waddr1] = 1'b0;
    end
    if (i_iss_valid && (i_iss_rd != '0)) begin
      w_busy_nxt[i_iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // A register being written by WB1 this cycle is served by the bypass, so it is not busy.
  always_comb begin
    o_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      o_rd_busy[k] = r_busy[i_rd_addr[k*AW +: AW]] &
                     ~(i_we1 && (i_waddr1 == i_rd_addr[k*AW +: AW]));
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Two-write, NUM_RD-read register file with write-first bypass and a load scoreboard.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter  int unsigned XLEN      = XLEN_DEF,
  parameter  int unsigned NREGS     = NREGS_DEF,
  parameter  int unsigned NUM_RD    = 2,
  parameter  int unsigned INIT_MODE = INIT_ZERO,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_RD*AW-1:0]   i_rd_addr,
  output logic [NUM_RD*XLEN-1:0] o_rd_data,
  output logic [NUM_RD-1:0]      o_rd_busy,
  input  logic                   i_we0,
  input  logic [AW-1:0]          i_waddr0,
  input  logic [XLEN-1:0]        i_wdata0,
  input  logic                   i_we1,
  input  logic [AW-1:0]          i_waddr1,
  input  logic [XLEN-1:0]        i_wdata1,
  input  logic                   i_iss_valid,
  input  logic [AW-1:0]          i_iss_rd,
  output logic                   o_stall,
  output logic                   o_wr_collide
);

  logic [XLEN-1:0] r_regs [NREGS];

  logic w_we0_eff;
  logic w_we1_eff;

  // Writes are ignored while reset is held, so reads show the init image.
  assign w_we0_eff = i_we0 & ~i_reset;
  assign w_we1_eff = i_we1 & ~i_reset;

  assign o_wr_collide = i_we0 & i_we1 & (i_waddr0 == i_waddr1) & (i_waddr0 != '0);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (INIT_MODE == INIT_INDEX) ? XLEN'(i) : '0;
      end
    end else begin
      if (i_we0 && (i_waddr0 != '0)) begin
        r_regs[i_waddr0] <= i_wdata0;
      end
      if (i_we1 && (i_waddr1 != '0)) begin
        r_regs[i_waddr1] <= i_wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    bypass_sel_e     w_sel;
    logic [XLEN-1:0] w_rdata;

    assign w_ra  = i_rd_addr[k*AW +: AW];
    assign w_sel = bypass_sel(32'(w_ra), w_we0_eff, 32'(i_waddr0), w_we1_eff, 32'(i_waddr1));

    always_comb begin
      w_rdata = '0;
      unique case (w_sel)
        SelWb1:   w_rdata = i_wdata1;
        SelWb0:   w_rdata = i_wdata0;
        SelArray: w_rdata = r_regs[w_ra];
        default:  w_rdata = '0;
      endcase
    end

    assign o_rd_data[k*XLEN +: XLEN] = w_rdata;
  end

  regfile_sb #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .i_we1       (i_we1),
    .i_waddr1    (i_waddr1),
    .i_rd_addr   (i_rd_addr),
    .o_rd_busy   (o_rd_busy)
  );

  assign o_stall = |o_rd_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Table-driven bench for regfile_mp_sb with INIT_MODE=1 and two read ports.
module tb_regfile_mp_sb;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned AW     = 5;

  logic                   clk;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   we0, we1, iss_valid;
  logic [AW-1:0]          waddr0, waddr1, iss_rd;
  logic [XLEN-1:0]        wdata0, wdata1;
  logic                   stall, wr_collide;

  regfile_mp_sb #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .NUM_RD    (NUM_RD),
    .INIT_MODE (1)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_we0        (we0),
    .i_waddr0     (waddr0),
    .i_wdata0     (wdata0),
    .i_we1        (we1),
    .i_waddr1     (waddr1),
    .i_wdata1     (wdata1),
    .i_iss_valid  (iss_valid),
    .i_iss_rd     (iss_rd),
    .o_stall      (stall),
    .o_wr_collide (wr_collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        es;
    logic        ec;
  } vec_t;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        es;
    logic        ec;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(input logic we0_v, input logic [4:0] wa0_v, input logic [31:0] wd0_v,
                              input logic we1_v, input logic [4:0] wa1_v, input logic [31:0] wd1_v,
                              input logic iv_v, input logic [4:0] ird_v,
                              input logic [4:0] ra0_v, input logic [4:0] ra1_v,
                              input logic [31:0] e0_v, input logic [31:0] e1_v,
                              input logic [1:0] eb_v, input logic es_v, input logic ec_v);
    vec_t v;
    v.we0 = we0_v; v.wa0 = wa0_v; v.wd0 = wd0_v;
    v.we1 = we1_v; v.wa1 = wa1_v; v.wd1 = wd1_v;
    v.iv  = iv_v;  v.ird = ird_v;
    v.ra0 = ra0_v; v.ra1 = ra1_v;
    v.e0  = e0_v;  v.e1  = e1_v;  v.eb = eb_v; v.es = es_v; v.ec = ec_v;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
    we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
    iss_valid = v.iv; iss_rd = v.ird;
    rd_addr = {v.ra1, v.ra0};
    e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.es = v.es; e.ec = v.ec;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " rd_data0"}, rd_data[31:0], e.e0);
    chk({tag, " rd_data1"}, rd_data[63:32], e.e1);
    chk({tag, " rd_busy"}, 32'(rd_busy), 32'(e.eb));
    chk({tag, " stall"}, 32'(stall), 32'(e.es));
    chk({tag, " wr_collide"}, 32'(wr_collide), 32'(e.ec));
  endtask

  initial begin
    // Cycle-by-cycle table; each row is checked combinationally before its clock edge.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 2'b00, 0, 0));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 31, 32'hDEADBEEF, 31, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 6, 32'h22, 6, 2'b00, 0, 1));
    vecs.push_back(mk(1, 0, 32'h99, 1, 0, 32'h77, 0, 0, 7, 0, 32'h22, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h22, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 9, 9, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 9, 2, 9, 2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 9, 32'h55, 0, 0, 9, 9, 32'h55, 32'h55, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 9, 8, 32'h55, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 12, 32'hC0, 1, 12, 12, 1, 32'hC0, 1, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 11, 32'hC0, 11, 2'b01, 1, 0));
    vecs.push_back(mk(1, 12, 32'h33, 0, 0, 0, 0, 0, 12, 12, 32'h33, 32'h33, 2'b11, 1, 0));
    vecs.push_back(mk(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 3, 4, 32'hA, 32'hB, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 32'hA, 32'hB, 2'b00, 0, 0));

    // Held in reset with a write aimed at r3: reads must still show the init image.
    reset = 1'b1;
    drive(mk(1, 3, 32'hAA, 0, 0, 0, 1, 3, 3, 31, 3, 31, 2'b00, 0, 0));
    #1;
    check_now("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0, 2'b00, 0, 0));
    #1;
    check_now("post-reset r3/r0");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_now($sformatf("v%0d", i));
    end

    // Load issued to r4 while ALU writes r4: data lands, busy stays set.
    @(negedge clk);
    drive(mk(1, 4, 32'h44, 0, 0, 0, 1, 4, 4, 5, 32'h44, 32'hDEADBEEF, 2'b00, 0, 0));
    #1;
    check_now("iss r4");
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 12, 32'h44, 32'h33, 2'b11, 1, 0));
    #1;
    check_now("r4 busy");
    #2;
    // Mid-cycle reset with a fresh write/issue to r6: both must be lost.
    reset = 1'b1;
    drive(mk(0, 0, 0, 1, 6, 32'h66, 1, 6, 4, 6, 4, 6, 2'b00, 0, 0));
    #1;
    check_now("async reset");
    @(negedge clk);
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 12, 6, 12, 2'b00, 0, 0));
    #1;
    check_now("after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
